// File: rtl/muldiv_iter.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a busy/done handshake for the hazard unit.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic               signed_op, in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes, one iteration step of each algorithm, and the final sign fix-up.
  // The remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  always_comb begin
    signed_op = ~op[0];
    in_sign_a = signed_op & a[WIDTH-1];
    in_sign_b = signed_op & b[WIDTH-1];
    abs_a     = in_sign_a ? -a : a;
    abs_b     = in_sign_b ? -b : b;
    mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    prod_mag  = {p_hi_q, p_lo_q};
    prod_fix  = (sign_a_q ^ sign_b_q) ? -prod_mag : prod_mag;
    quo_fix   = (sign_a_q ^ sign_b_q) ? -p_lo_q : p_lo_q;
    rem_fix   = sign_a_q ? -p_hi_q : p_hi_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          state_d  = S_CALC;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          p_hi_d   = '0;
          opnd_d   = op[1] ? abs_b : abs_a;
          p_lo_d   = op[1] ? abs_a : abs_b;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (is_div_q) begin
            p_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], div_ge};
          end else begin
            p_hi_d = mul_sum[WIDTH:1];
            p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!cancel) begin
          done_d = 1'b1;
          hi_d   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: vector table with a result scoreboard,
// plus hand-written cancel, same-cycle start/cancel, ignored-start and async-reset sequences.
module tb_muldiv_iter;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetn, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add_vec(input string n, input logic [1:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el);
    vec_t v;
    v.name = n; v.op = o; v.a = x; v.b = y; v.hi = eh; v.lo = el;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one start pulse at a negedge; operands are scrambled after the accept edge.
  task automatic issue(input string n, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.name = n; e.hi = eh; e.lo = el;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Count cycles to done, then pop and compare; optionally pulse a start mid-operation.
  task automatic wait_done(input bit inject);
    int   n = 0;
    bit   seen = 1'b0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (n < 60 && !seen) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        n++;
        if (inject && n == 5) begin
          start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        end
        if (inject && n == 6) start = 1'b0;
      end
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=done required=pending_entry");
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done_within_60", e.name);
      return;
    end
    chk({e.name, "_latency"}, W'(n), W'(W + 1));
    chk({e.name, "_busy_held"}, W'(busy_ok), W'(1));
    chk({e.name, "_busy_at_done"}, W'(busy), W'(0));
    chk({e.name, "_hi"}, hi, e.hi);
    chk({e.name, "_lo"}, lo, e.lo);
    @(negedge clk);
    chk({e.name, "_done_width"}, W'(done), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;

    add_vec("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add_vec("mult_neg3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add_vec("mult_minxmin",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    add_vec("mult_maxxmax",  2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    add_vec("mult_0xneg1",   2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
    add_vec("multu_shift",   2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    add_vec("div_neg7by2",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_vec("divu_7by2",     2'b11, 32'd7,         32'd2,         32'd1,         32'd3);
    add_vec("div_7byneg2",   2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    add_vec("div_overflow",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    add_vec("divu_5by0",     2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    add_vec("div_neg5by0",   2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001);
    add_vec("div_n100byn7",  2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);

    repeat (2) @(negedge clk);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_hi", hi, W'(0));
    chk("reset_lo", lo, W'(0));
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
      wait_done(1'b0);
    end

    // start and cancel together in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", W'(busy), W'(0));
    @(negedge clk);
    chk("start_cancel_done", W'(done), W'(0));

    // cancel a MULTU mid-flight, hi/lo keep the previous result
    issue("multu_cancel", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    repeat (9) @(negedge clk);
    chk("cancel_busy_before", W'(busy), W'(1));
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy_after", W'(busy), W'(0));
    chk("cancel_done", W'(done), W'(0));
    chk("cancel_hi_kept", hi, vecs[vecs.size()-1].hi);
    chk("cancel_lo_kept", lo, vecs[vecs.size()-1].lo);
    issue("divu_100by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(1'b0);

    // start pulsed while busy is ignored
    issue("mult_ignored_start", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    wait_done(1'b1);

    // asynchronous reset in the middle of a DIV
    issue("div_reset", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", W'(busy), W'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_busy", W'(busy), W'(0));
    chk("async_reset_done", W'(done), W'(0));
    chk("async_reset_hi", hi, W'(0));
    chk("async_reset_lo", lo, W'(0));
    @(negedge clk);
    resetn = 1'b1;
    issue("divu_after_reset", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b1);
    wait_done(1'b0);

    chk("scoreboard_drained", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
